// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings and FSM states for the multiply/divide unit
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  function automatic logic op_is_signed(input op_e op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational iteration: shift-add multiply or restoring divide
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic                 is_div_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [2*WIDTH-1:0]   acc_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  always_comb begin
    // Multiply: upper half accumulates, lower half holds the remaining multiplier bits.
    sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, b_i} : '0);
    // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
    trial = acc_i[2*WIDTH-1:WIDTH-1];
    diff  = trial - {1'b0, b_i};
    acc_o = {sum, acc_i[WIDTH-1:1]};
    if (is_div_i) begin
      if (!diff[WIDTH]) begin
        acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic             kill_i,
  input  logic             wr_hi_i,
  input  logic             wr_lo_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             divzero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int W2 = 2 * WIDTH;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_a_q, neg_a_d;
  logic             bzero_q, bzero_d;
  logic             divzero_q, divzero_d;

  op_e              op_in;
  logic             in_signed;
  logic             is_div;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [W2-1:0]    step_acc, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign op_in     = op_e'(op_i);
  assign in_signed = op_is_signed(op_in);
  assign is_div    = op_is_div(op_q);
  assign mag_a     = (in_signed && rs_i[WIDTH-1]) ? -rs_i : rs_i;
  assign mag_b     = (in_signed && rt_i[WIDTH-1]) ? -rt_i : rt_i;

  // Sign flags are only ever set for signed ops, so unsigned results pass through untouched.
  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_a_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (is_div),
    .acc_i    (acc_q),
    .b_i      (b_q),
    .acc_o    (step_acc)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_res_d = neg_res_q;
    neg_a_d   = neg_a_q;
    bzero_d   = bzero_q;
    divzero_d = divzero_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d      = op_in;
          a_d       = rs_i;
          b_d       = mag_b;
          acc_d     = {{WIDTH{1'b0}}, mag_a};
          neg_res_d = in_signed && (rs_i[WIDTH-1] ^ rt_i[WIDTH-1]);
          neg_a_d   = in_signed && rs_i[WIDTH-1];
          bzero_d   = (rt_i == '0);
          cnt_d     = '0;
          divzero_d = 1'b0;
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        if (kill_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (kill_i) begin
          state_d = S_IDLE;
        end else begin
          if (!is_div) begin
            hi_d = prod_fix[W2-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end else if (bzero_q) begin
            hi_d = a_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
          divzero_d = is_div && bzero_q;
          state_d   = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // MTHI/MTLO only land outside CALC/FIX, so they never collide with the FIX write.
    if (!busy_o) begin
      if (wr_hi_i) hi_d = wdata_i;
      if (wr_lo_i) lo_d = wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      op_q      <= OP_MULT;
      cnt_q     <= '0;
      acc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_res_q <= 1'b0;
      neg_a_q   <= 1'b0;
      bzero_q   <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_res_q <= neg_res_d;
      neg_a_q   <= neg_a_d;
      bzero_q   <= bzero_d;
      divzero_q <= divzero_d;
    end
  end

  assign busy_o    = (state_q == S_CALC) || (state_q == S_FIX);
  assign done_o    = (state_q == S_DONE);
  assign divzero_o = divzero_q;
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;

endmodule
